// File: rtl/csela_pkg.sv
// Shared definitions for the carry-select adder family: FSM encodings,
// default datapath sizes and the chunk-counter sizing helper.
package csela_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;

    function automatic int nchunk_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter must stay at least one bit wide so NCHUNK=1 still elaborates.
    function automatic int idx_bits(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/csela_serial_add_ctrl_cselaxbit.sv
// Combinational carry-select adder: 4-bit blocks each precompute sums for
// carry-in 0 and 1, and the incoming block carry picks one.
module CSelAxbit #(
    parameter int size = 16
) (
    input  logic [size-1:0] i_a,
    input  logic [size-1:0] i_b,
    input  logic            i_cin,
    output logic [size-1:0] o_sum,
    output logic            o_cout
);

    localparam int NBLK = size / 4;

    logic [4:0] w_s0;
    logic [4:0] w_s1;
    logic       w_c;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_s0  = '0;
        w_s1  = '0;
        w_c   = i_cin;
        o_sum = '0;
        for (int k = 0; k < NBLK; k++) begin
            w_s0 = {1'b0, i_a[4*k +: 4]} + {1'b0, i_b[4*k +: 4]};
            w_s1 = w_s0 + 5'd1;
            o_sum[4*k +: 4] = w_c ? w_s1[3:0] : w_s0[3:0];
            w_c = w_c ? w_s1[4] : w_s0[4];
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/csela_serial_add_ctrl.sv
// WIDTH-bit add/subtract built by running one CHUNK-bit carry-select adder
// over WIDTH/CHUNK cycles, with valid/ready handshakes on both sides.
module csela_serial_add_ctrl
    import csela_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
    localparam int IDXW   = idx_bits(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_res_next;

    CSelAxbit #(.size(CHUNK)) u_chunk (
        .i_a    (r_opa[CHUNK-1:0]),
        .i_b    (r_opb[CHUNK-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Chunk results enter at the top so the first chunk ends up at bit 0.
    generate
        if (NCHUNK == 1) begin : g_one
            assign w_res_next = w_sum;
        end else begin : g_many
            assign w_res_next = {w_sum, r_res[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign w_msb_cin = r_opa[CHUNK-1] ^ r_opb[CHUNK-1] ^ w_sum[CHUNK-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opa   <= a;
                        r_opb   <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_opa   <= r_opa >> CHUNK;
                    r_opb   <= r_opb >> CHUNK;
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_cout;
                        r_ovf   <= w_msb_cin ^ w_cout;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign sum       = r_res;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
